// File: rtl/rs_decode_stream_in_ctrl_if.sv
// Stream, data-memory and line-decoder signals of the RS receive-side controller.
// master is the controller; slave is the surrounding source/memory/decoder.
interface rs_decode_stream_in_ctrl_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8,
    parameter int BLK_W  = 8
);
    logic              src_decoder_meta_val;
    logic [BLK_W-1:0]  src_decoder_meta_num_blocks;
    logic [BLK_W-1:0]  src_decoder_meta_lines_per_block;
    logic              decoder_src_meta_rdy;

    logic              src_decoder_data_val;
    logic [DATA_W-1:0] src_decoder_data;
    logic              src_decoder_data_last;
    logic              decoder_src_data_rdy;

    logic              data_mem_wr_val;
    logic [ADDR_W-1:0] data_mem_wr_addr;
    logic [DATA_W-1:0] data_mem_wr_data;
    logic              data_mem_rd_req_val;
    logic [ADDR_W-1:0] data_mem_rd_req_addr;
    logic              data_mem_rd_resp_val;
    logic [DATA_W-1:0] data_mem_rd_resp_data;
    logic              data_mem_rd_resp_rdy;

    logic              stream_decode_line_decode_val;
    logic [DATA_W-1:0] stream_decode_line_decode_data;
    logic              stream_decode_line_decode_parity;
    logic              line_decode_stream_decode_rdy;

    logic              decode_done;
    logic              proto_err;

    modport master (
        input  src_decoder_meta_val, src_decoder_meta_num_blocks, src_decoder_meta_lines_per_block,
        output decoder_src_meta_rdy,
        input  src_decoder_data_val, src_decoder_data, src_decoder_data_last,
        output decoder_src_data_rdy,
        output data_mem_wr_val, data_mem_wr_addr, data_mem_wr_data,
        output data_mem_rd_req_val, data_mem_rd_req_addr,
        input  data_mem_rd_resp_val, data_mem_rd_resp_data,
        output data_mem_rd_resp_rdy,
        output stream_decode_line_decode_val, stream_decode_line_decode_data,
        output stream_decode_line_decode_parity,
        input  line_decode_stream_decode_rdy,
        output decode_done, proto_err
    );

    modport slave (
        output src_decoder_meta_val, src_decoder_meta_num_blocks, src_decoder_meta_lines_per_block,
        input  decoder_src_meta_rdy,
        output src_decoder_data_val, src_decoder_data, src_decoder_data_last,
        input  decoder_src_data_rdy,
        input  data_mem_wr_val, data_mem_wr_addr, data_mem_wr_data,
        input  data_mem_rd_req_val, data_mem_rd_req_addr,
        output data_mem_rd_resp_val, data_mem_rd_resp_data,
        input  data_mem_rd_resp_rdy,
        input  stream_decode_line_decode_val, stream_decode_line_decode_data,
        input  stream_decode_line_decode_parity,
        output line_decode_stream_decode_rdy,
        input  decode_done, proto_err
    );
endinterface

// File: rtl/rs_decode_stream_in_ctrl.sv
// Buffers all data lines of an RS request, then on each parity line replays that
// block's data lines from memory to the line decoder and forwards the parity line.
//
// state         | meaning
// S_READY       | waiting for request metadata
// S_STORE_DATA  | writing incoming data lines to the data memory
// S_WAIT_PARITY | waiting for the next block's parity line (held upstream)
// S_REPLAY      | reading the block's data lines back out to the decoder
// S_SEND_PARITY | forwarding the parity line to the decoder
module rs_decode_stream_in_ctrl #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8,
    parameter int BLK_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    rs_decode_stream_in_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_READY,
        S_STORE_DATA,
        S_WAIT_PARITY,
        S_REPLAY,
        S_SEND_PARITY
    } state_t;

    state_t            state_q, state_d;
    logic [BLK_W-1:0]  num_blocks_q, num_blocks_d;
    logic [BLK_W-1:0]  lpb_q, lpb_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0]  line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              proto_err_q, proto_err_d;
    logic              run_q;
    logic [DATA_W-1:0] line_sel;

    logic last_line, last_blk;
    assign last_line = (line_cnt_q == lpb_q - 1'b1);
    assign last_blk  = (blk_cnt_q == num_blocks_q - 1'b1);

    // run_q keeps meta_rdy low while reset is held and for the first cycle after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_READY;
            num_blocks_q <= '0;
            lpb_q        <= '0;
            blk_cnt_q    <= '0;
            line_cnt_q   <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            proto_err_q  <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_blocks_q <= num_blocks_d;
            lpb_q        <= lpb_d;
            blk_cnt_q    <= blk_cnt_d;
            line_cnt_q   <= line_cnt_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            proto_err_q  <= proto_err_d;
            run_q        <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_blocks_d = num_blocks_q;
        lpb_d        = lpb_q;
        blk_cnt_d    = blk_cnt_q;
        line_cnt_d   = line_cnt_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        proto_err_d  = proto_err_q;

        line_sel                             = bus.src_decoder_data;
        bus.decoder_src_meta_rdy             = 1'b0;
        bus.decoder_src_data_rdy             = 1'b0;
        bus.data_mem_wr_val                  = 1'b0;
        bus.data_mem_rd_req_val              = 1'b0;
        bus.data_mem_rd_resp_rdy             = 1'b0;
        bus.stream_decode_line_decode_val    = 1'b0;
        bus.stream_decode_line_decode_parity = 1'b0;
        bus.decode_done                      = 1'b0;

        case (state_q)
            S_READY: begin
                bus.decoder_src_meta_rdy = run_q;
                if (run_q && bus.src_decoder_meta_val) begin
                    if (bus.src_decoder_meta_num_blocks != '0 &&
                        bus.src_decoder_meta_lines_per_block != '0) begin
                        num_blocks_d = bus.src_decoder_meta_num_blocks;
                        lpb_d        = bus.src_decoder_meta_lines_per_block;
                        blk_cnt_d    = '0;
                        line_cnt_d   = '0;
                        wr_addr_d    = '0;
                        rd_addr_d    = '0;
                        proto_err_d  = 1'b0;
                        state_d      = S_STORE_DATA;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end

            S_STORE_DATA: begin
                bus.decoder_src_data_rdy = 1'b1;
                if (bus.src_decoder_data_val) begin
                    bus.data_mem_wr_val = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (bus.src_decoder_data_last) begin
                        proto_err_d = 1'b1;
                        state_d     = S_READY;
                    end else if (last_line) begin
                        line_cnt_d = '0;
                        if (last_blk) begin
                            blk_cnt_d = '0;
                            state_d   = S_WAIT_PARITY;
                        end else begin
                            blk_cnt_d = blk_cnt_q + 1'b1;
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
            end

            S_WAIT_PARITY: begin
                if (bus.src_decoder_data_val) begin
                    bus.data_mem_rd_req_val = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    state_d   = S_REPLAY;
                end
            end

            S_REPLAY: begin
                line_sel                          = bus.data_mem_rd_resp_data;
                bus.stream_decode_line_decode_val = bus.data_mem_rd_resp_val;
                bus.data_mem_rd_resp_rdy          = bus.line_decode_stream_decode_rdy;
                if (bus.data_mem_rd_resp_val && bus.line_decode_stream_decode_rdy) begin
                    if (last_line) begin
                        line_cnt_d = '0;
                        state_d    = S_SEND_PARITY;
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                        bus.data_mem_rd_req_val = 1'b1;
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end

            S_SEND_PARITY: begin
                bus.stream_decode_line_decode_val    = bus.src_decoder_data_val;
                bus.stream_decode_line_decode_parity = 1'b1;
                bus.decoder_src_data_rdy             = bus.line_decode_stream_decode_rdy;
                if (bus.src_decoder_data_val && bus.line_decode_stream_decode_rdy) begin
                    if (last_blk) begin
                        if (bus.src_decoder_data_last) bus.decode_done = 1'b1;
                        else                           proto_err_d = 1'b1;
                        state_d = S_READY;
                    end else if (bus.src_decoder_data_last) begin
                        proto_err_d = 1'b1;
                        state_d     = S_READY;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                        state_d   = S_WAIT_PARITY;
                    end
                end
            end

            default: state_d = S_READY;
        endcase
    end

    assign bus.data_mem_wr_addr               = wr_addr_q;
    assign bus.data_mem_wr_data               = bus.src_decoder_data;
    assign bus.data_mem_rd_req_addr           = rd_addr_q;
    assign bus.stream_decode_line_decode_data = line_sel;
    assign bus.proto_err                      = proto_err_q;

endmodule

// File: tb/tb_rs_decode_stream_in_ctrl.sv
// Self-checking bench: random lines through a behavioural memory/decoder model,
// compared against the expected write and decoder sequences.
module tb_rs_decode_stream_in_ctrl;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 8;
    localparam int BLK_W  = 8;
    localparam int LIMIT  = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_decode_stream_in_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_W(BLK_W)) bus ();

    rs_decode_stream_in_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;

    // memory model: write-first, one-cycle read latency, response held until taken
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              pend;
    logic [DATA_W-1:0] pend_data;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            pend_data <= '0;
        end else begin
            if (bus.data_mem_wr_val) mem[bus.data_mem_wr_addr] <= bus.data_mem_wr_data;
            if (pend && bus.data_mem_rd_resp_rdy) pend <= 1'b0;
            if (bus.data_mem_rd_req_val) begin
                pend <= 1'b1;
                pend_data <= (bus.data_mem_wr_val && bus.data_mem_wr_addr == bus.data_mem_rd_req_addr)
                             ? bus.data_mem_wr_data : mem[bus.data_mem_rd_req_addr];
            end
        end
    end
    assign bus.data_mem_rd_resp_val  = pend;
    assign bus.data_mem_rd_resp_data = pend_data;

    // observation of every handshake on the DUT boundary
    logic [DATA_W:0]   obs_q [$];
    int                wr_a_q [$];
    logic [DATA_W-1:0] wr_d_q [$];
    int cycle = 0, done_cnt = 0, src_hs_cyc = 0, meta_hs_cyc = 0, meta_hs_cnt = 0;
    int rr_seen = 0, rr_bad = 0;
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst_n) begin
            if (bus.stream_decode_line_decode_val && bus.line_decode_stream_decode_rdy)
                obs_q.push_back({bus.stream_decode_line_decode_parity, bus.stream_decode_line_decode_data});
            if (bus.data_mem_wr_val) begin
                wr_a_q.push_back(int'(bus.data_mem_wr_addr));
                wr_d_q.push_back(bus.data_mem_wr_data);
            end
            if (bus.decode_done) done_cnt <= done_cnt + 1;
            if (bus.src_decoder_data_val && bus.decoder_src_data_rdy) src_hs_cyc <= cycle;
            if (bus.src_decoder_meta_val && bus.decoder_src_meta_rdy) begin
                meta_hs_cyc <= cycle;
                meta_hs_cnt <= meta_hs_cnt + 1;
            end
            if (pend) begin
                rr_seen <= rr_seen + 1;
                if (bus.data_mem_rd_resp_rdy !== bus.line_decode_stream_decode_rdy) rr_bad <= rr_bad + 1;
            end
        end
    end

    bit rand_rdy = 1'b0;
    initial begin
        bus.line_decode_stream_decode_rdy = 1'b1;
        forever begin
            @(negedge clk);
            bus.line_decode_stream_decode_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_meta(input int nb, input int lpb);
        int t = 0;
        bus.src_decoder_meta_val = 1'b1;
        bus.src_decoder_meta_num_blocks = BLK_W'(nb);
        bus.src_decoder_meta_lines_per_block = BLK_W'(lpb);
        do begin @(posedge clk); t++; end while (!bus.decoder_src_meta_rdy && t < LIMIT);
        check("meta_timeout", (t >= LIMIT), 0);
        @(negedge clk);
        bus.src_decoder_meta_val = 1'b0;
    endtask

    task automatic send_line(input logic [DATA_W-1:0] d, input logic l);
        int t = 0;
        bus.src_decoder_data_val = 1'b1;
        bus.src_decoder_data = d;
        bus.src_decoder_data_last = l;
        do begin @(posedge clk); t++; end while (!bus.decoder_src_data_rdy && t < LIMIT);
        check("line_timeout", (t >= LIMIT), 0);
        @(negedge clk);
    endtask

    // Full request; expectations come straight from the stream format:
    // writes at 0..N-1, decoder sees each block's data lines followed by its parity.
    task automatic do_request(input int nb, input int lpb);
        logic [DATA_W-1:0] dl [$];
        logic [DATA_W-1:0] pl [$];
        int ob = obs_q.size();
        int wb = wr_a_q.size();
        int db = done_cnt;
        send_meta(nb, lpb);
        check("err_clear_on_meta", bus.proto_err, 0);
        for (int i = 0; i < nb * lpb; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.src_decoder_data_val = 1'b0;
                @(negedge clk);
            end
            dl.push_back(rand_line());
            send_line(dl[i], 1'b0);
        end
        for (int b = 0; b < nb; b++) begin
            pl.push_back(rand_line());
            send_line(pl[b], (b == nb - 1));
        end
        bus.src_decoder_data_val = 1'b0;
        bus.src_decoder_data_last = 1'b0;
        check("wr_count", wr_a_q.size() - wb, nb * lpb);
        for (int i = 0; i < nb * lpb && wb + i < wr_a_q.size(); i++) begin
            check("wr_addr", wr_a_q[wb+i], i % (1 << ADDR_W));
            check("wr_data", wr_d_q[wb+i], dl[i]);
        end
        check("dec_count", obs_q.size() - ob, nb * (lpb + 1));
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k <= lpb; k++) begin
                int idx = ob + b * (lpb + 1) + k;
                if (idx < obs_q.size())
                    check("dec_line", obs_q[idx], (k < lpb) ? {1'b0, dl[b*lpb+k]} : {1'b1, pl[b]});
            end
        end
        check("done_once", done_cnt - db, 1);
        check("proto_err_ok", bus.proto_err, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_meta_rdy"}, bus.decoder_src_meta_rdy, 0);
        check({tag, "_data_rdy"}, bus.decoder_src_data_rdy, 0);
        check({tag, "_wr_val"},   bus.data_mem_wr_val, 0);
        check({tag, "_wr_addr"},  bus.data_mem_wr_addr, 0);
        check({tag, "_rd_val"},   bus.data_mem_rd_req_val, 0);
        check({tag, "_rd_addr"},  bus.data_mem_rd_req_addr, 0);
        check({tag, "_resp_rdy"}, bus.data_mem_rd_resp_rdy, 0);
        check({tag, "_dec_val"},  bus.stream_decode_line_decode_val, 0);
        check({tag, "_done"},     bus.decode_done, 0);
        check({tag, "_err"},      bus.proto_err, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int ob, wb, db, t;
        bus.src_decoder_meta_val = 1'b0;
        bus.src_decoder_meta_num_blocks = '0;
        bus.src_decoder_meta_lines_per_block = '0;
        bus.src_decoder_data_val = 1'b0;
        bus.src_decoder_data = '0;
        bus.src_decoder_data_last = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 2 blocks x 3 lines, decoder always ready
        do_request(2, 3);

        // same shape, random decoder backpressure
        rand_rdy = 1'b1;
        do_request(2, 3);
        do_request(3, 2);
        check("resp_rdy_tracks", rr_bad, 0);
        check("resp_seen", (rr_seen > 0), 1);
        rand_rdy = 1'b0;

        // 1x1 request; next meta must be taken the cycle READY is re-entered
        ob = obs_q.size(); db = done_cnt;
        send_meta(1, 1);
        d = rand_line();
        send_line(d, 1'b0);
        bus.src_decoder_meta_val = 1'b1;
        bus.src_decoder_meta_num_blocks = 8'd2;
        bus.src_decoder_meta_lines_per_block = 8'd2;
        begin
            logic [DATA_W-1:0] p;
            int mc;
            p = rand_line();
            mc = meta_hs_cnt;
            send_line(p, 1'b1);
            bus.src_decoder_data_val = 1'b0;
            bus.src_decoder_data_last = 1'b0;
            t = 0;
            while (meta_hs_cnt == mc && t < LIMIT) begin @(negedge clk); t++; end
            bus.src_decoder_meta_val = 1'b0;
            check("meta_same_cycle", meta_hs_cyc - src_hs_cyc, 1);
            check("one_dec_count", obs_q.size() - ob, 2);
            if (obs_q.size() - ob == 2) begin
                check("one_d0", obs_q[ob], {1'b0, d});
                check("one_p0", obs_q[ob+1], {1'b1, p});
            end
            check("one_done", done_cnt - db, 1);
        end

        // 2x2 request with last on D2: protocol error, no done
        db = done_cnt;
        send_line(rand_line(), 1'b0);
        send_line(rand_line(), 1'b0);
        send_line(rand_line(), 1'b1);
        bus.src_decoder_data_val = 1'b0;
        bus.src_decoder_data_last = 1'b0;
        @(negedge clk);
        check("early_last_err", bus.proto_err, 1);
        check("early_last_ready", bus.decoder_src_meta_rdy, 1);
        check("early_last_nodone", done_cnt - db, 0);
        do_request(1, 2);

        // zero-sized metadata fields
        wb = wr_a_q.size();
        send_meta(0, 3);
        check("nb0_err", bus.proto_err, 1);
        check("nb0_ready", bus.decoder_src_meta_rdy, 1);
        send_meta(3, 0);
        check("lpb0_err", bus.proto_err, 1);
        check("lpb0_ready", bus.decoder_src_meta_rdy, 1);
        repeat (2) @(negedge clk);
        check("zero_no_writes", wr_a_q.size() - wb, 0);

        // async reset in the middle of block 1 replay
        ob = obs_q.size();
        send_meta(2, 2);
        for (int i = 0; i < 4; i++) send_line(rand_line(), 1'b0);
        send_line(rand_line(), 1'b0);
        bus.src_decoder_data = rand_line();
        bus.src_decoder_data_last = 1'b1;
        t = 0;
        while (obs_q.size() < ob + 3 && t < LIMIT) begin @(negedge clk); t++; end
        check("pre_reset_timeout", (t >= LIMIT), 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        bus.src_decoder_data_val = 1'b0;
        bus.src_decoder_data_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_rdy = 1'b1;
        do_request(2, 3);
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=expired expected=finish");
        $fatal(1, "timeout");
    end
endmodule
